page_table_walker: RTL

Hardware page-table walker between the TLB and the page-table memory in the virtual-memory subsystem. On a TLB miss it accepts the 8-bit VPN of the faulting 12-bit virtual address and reads the page-table entry (PTE). Optionally it writes back the referenced/dirty bits, then returns either a 6-bit PPN refill or a page-fault indication. The TLB consumes the response to refill an entry and form the 10-bit physical address for the cache.

---
 rtl/page_table_walker.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/page_table_walker.sv
`default_nettype none
// ============================================================================
// Module      : page_table_walker
// Description : TLB-miss page-table walker. Reads the PTE for a VPN, returns a
//               PPN refill or a page fault. Define PTW_AD_UPDATE_EN to enable
//               write-back of the referenced/dirty bits.
// Revision    : 1.0 - initial release
// ============================================================================
module page_table_walker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_vpn,
    input  logic             req_write,
    output logic             pt_rd_en,
    output logic [7:0]       pt_addr,
    input  logic [8:0]       pt_rdata,
    output logic             pt_wr_en,
    output logic [8:0]       pt_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [7:0]       resp_vpn,
    output logic [5:0]       resp_ppn,
    output logic             resp_dirty,
    output logic             resp_fault,
    output logic [CNT_W-1:0] walk_cnt,
    output logic [CNT_W-1:0] fault_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WAIT   = 3'd2,
`ifdef PTW_AD_UPDATE_EN
        S_UPDATE = 3'd3,
`endif
        S_RESP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       vpn_q, vpn_d;
    logic             write_q, write_d;
    logic [8:0]       pte_q, pte_d;
    logic             req_ready_q, req_ready_d;
    logic             pt_rd_en_q, pt_rd_en_d;
    logic [7:0]       pt_addr_q, pt_addr_d;
    logic             resp_valid_q, resp_valid_d;
    logic [7:0]       resp_vpn_q, resp_vpn_d;
    logic [5:0]       resp_ppn_q, resp_ppn_d;
    logic             resp_dirty_q, resp_dirty_d;
    logic             resp_fault_q, resp_fault_d;
    logic [CNT_W-1:0] walk_cnt_q, walk_cnt_d;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic             resp_hs;

`ifdef PTW_AD_UPDATE_EN
    logic             pt_wr_en_q, pt_wr_en_d;
    logic [8:0]       pt_wdata_q, pt_wdata_d;
    logic             update_needed;

    assign update_needed = pt_rdata[8] & (~pt_rdata[7] | (write_q & ~pt_rdata[6]));
`endif

    assign resp_hs = resp_valid_q & resp_ready;

    always_comb begin
        state_d = state_q;
        vpn_d   = vpn_q;
        write_d = write_q;
        pte_d   = pte_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    vpn_d   = req_vpn;
                    write_d = req_write;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                pte_d = pt_rdata;
`ifdef PTW_AD_UPDATE_EN
                state_d = update_needed ? S_UPDATE : S_RESP;
`else
                state_d = S_RESP;
`endif
            end
`ifdef PTW_AD_UPDATE_EN
            S_UPDATE: state_d = S_RESP;
`endif
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        req_ready_d  = (state_d == S_IDLE);
        pt_rd_en_d   = (state_d == S_READ);
        pt_addr_d    = (state_d == S_IDLE) ? 8'h00 : vpn_d;
        resp_valid_d = (state_d == S_RESP);

        resp_vpn_d   = 8'h00;
        resp_ppn_d   = 6'h00;
        resp_dirty_d = 1'b0;
        resp_fault_d = 1'b0;
        if (state_d == S_RESP && state_q == S_RESP) begin
            resp_vpn_d   = resp_vpn_q;
            resp_ppn_d   = resp_ppn_q;
            resp_dirty_d = resp_dirty_q;
            resp_fault_d = resp_fault_q;
        end else if (state_d == S_RESP) begin
            // A valid write either found dirty set or is setting it now.
            resp_vpn_d   = vpn_q;
            resp_fault_d = ~pte_d[8];
            resp_ppn_d   = pte_d[8] ? pte_d[5:0] : 6'h00;
            resp_dirty_d = pte_d[8] & (pte_d[6] | write_q);
        end

`ifdef PTW_AD_UPDATE_EN
        pt_wr_en_d = (state_d == S_UPDATE);
        pt_wdata_d = (state_d == S_UPDATE) ?
                     {2'b11, pt_rdata[6] | write_q, pt_rdata[5:0]} : 9'h000;
`endif

        walk_cnt_d  = walk_cnt_q;
        fault_cnt_d = fault_cnt_q;
        if (resp_hs && walk_cnt_q != C_CNT_MAX) begin
            walk_cnt_d = walk_cnt_q + C_CNT_ONE;
        end
        if (resp_hs && resp_fault_q && fault_cnt_q != C_CNT_MAX) begin
            fault_cnt_d = fault_cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vpn_q        <= 8'h00;
            write_q      <= 1'b0;
            pte_q        <= 9'h000;
            req_ready_q  <= 1'b1;
            pt_rd_en_q   <= 1'b0;
            pt_addr_q    <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_vpn_q   <= 8'h00;
            resp_ppn_q   <= 6'h00;
            resp_dirty_q <= 1'b0;
            resp_fault_q <= 1'b0;
            walk_cnt_q   <= '0;
            fault_cnt_q  <= '0;
`ifdef PTW_AD_UPDATE_EN
            pt_wr_en_q   <= 1'b0;
            pt_wdata_q   <= 9'h000;
`endif
        end else begin
            state_q      <= state_d;
            vpn_q        <= vpn_d;
            write_q      <= write_d;
            pte_q        <= pte_d;
            req_ready_q  <= req_ready_d;
            pt_rd_en_q   <= pt_rd_en_d;
            pt_addr_q    <= pt_addr_d;
            resp_valid_q <= resp_valid_d;
            resp_vpn_q   <= resp_vpn_d;
            resp_ppn_q   <= resp_ppn_d;
            resp_dirty_q <= resp_dirty_d;
            resp_fault_q <= resp_fault_d;
            walk_cnt_q   <= walk_cnt_d;
            fault_cnt_q  <= fault_cnt_d;
`ifdef PTW_AD_UPDATE_EN
            pt_wr_en_q   <= pt_wr_en_d;
            pt_wdata_q   <= pt_wdata_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign pt_rd_en   = pt_rd_en_q;
    assign pt_addr    = pt_addr_q;
    assign resp_valid = resp_valid_q;
    assign resp_vpn   = resp_vpn_q;
    assign resp_ppn   = resp_ppn_q;
    assign resp_dirty = resp_dirty_q;
    assign resp_fault = resp_fault_q;
    assign walk_cnt   = walk_cnt_q;
    assign fault_cnt  = fault_cnt_q;

`ifdef PTW_AD_UPDATE_EN
    assign pt_wr_en = pt_wr_en_q;
    assign pt_wdata = pt_wdata_q;
`else
    assign pt_wr_en = 1'b0;
    assign pt_wdata = 9'h000;
`endif

endmodule
`default_nettype wire
